// File: rtl/uart_pkg.sv
// Shared UART constants, receive-line state type and the "HELLO" character table.
package uart_pkg;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_H  = 8'h48;
    localparam logic [7:0] CHAR_E  = 8'h45;
    localparam logic [7:0] CHAR_L  = 8'h4C;
    localparam logic [7:0] CHAR_O  = 8'h4F;

    localparam int unsigned HELLO_LEN = 5;

    typedef enum logic {COLLECT, HOLD} rx_line_state_e;

    // Character expected at position idx of "HELLO".
    function automatic logic [7:0] hello_char(input int unsigned idx);
        logic [7:0] c;
        case (idx)
            0:       c = CHAR_H;
            1:       c = CHAR_E;
            2, 3:    c = CHAR_L;
            default: c = CHAR_O;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/uart_rise_detect.sv
// Rising-edge detector: registers the previous value and pulses for one cycle on a 0->1 change.
module uart_rise_detect (
    input  logic Clk,
    input  logic Rst_n,
    input  logic din,
    output logic rise
);

    logic prev_q;

    // Previous-cycle copy of the input; clears on reset so a level held across reset counts once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= din;
        end
    end

    assign rise = din & ~prev_q;

endmodule

// File: rtl/uart_rx_line_buffer.sv
// Collects received bytes into a line until TERM, then hands the line to a reader byte by byte.
module uart_rx_line_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter logic [7:0]  TERM  = CHAR_CR,
    parameter logic [7:0]  SKIP  = CHAR_LF
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     RxDone,
    input  logic [7:0]               RxData,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     rd_valid,
    output logic                     line_ready,
    output logic [$clog2(DEPTH):0]   line_len,
    output logic                     hello_match,
    output logic                     overflow,
    output logic                     rx_drop
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CntW = AW + 1;

    rx_line_state_e  state_q, state_d;
    logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
    logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] line_len_q, line_len_d;
    logic            line_ready_q, line_ready_d;
    logic            hello_q, hello_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            overflow_q, overflow_d;
    logic            rx_drop_q, rx_drop_d;
    logic            mem_we;
    logic            accept;
    logic            hello_hit;
    logic [7:0]      line_mem_q [DEPTH];

    uart_rise_detect u_rise (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .din   (RxDone),
        .rise  (accept)
    );

    if (DEPTH >= HELLO_LEN) begin : g_hello
        // Stored bytes spell exactly "HELLO"; checked against the count about to become line_len.
        always_comb begin
            hello_hit = (wr_cnt_q == CntW'(HELLO_LEN));
            for (int unsigned i = 0; i < HELLO_LEN; i++) begin
                if (line_mem_q[AW'(i)] != hello_char(i)) begin
                    hello_hit = 1'b0;
                end
            end
        end
    end else begin : g_no_hello
        assign hello_hit = 1'b0;
    end

    // Next-state and output decode for the collect/hold handshake.
    always_comb begin
        state_d      = state_q;
        wr_cnt_d     = wr_cnt_q;
        rd_ptr_d     = rd_ptr_q;
        line_len_d   = line_len_q;
        line_ready_d = line_ready_q;
        hello_d      = hello_q;
        rd_data_d    = rd_data_q;
        rd_valid_d   = 1'b0;
        overflow_d   = 1'b0;
        rx_drop_d    = 1'b0;
        mem_we       = 1'b0;

        unique case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (RxData == SKIP) begin
                        // Discarded silently.
                    end else if (RxData == TERM) begin
                        // Empty lines are dropped and collection simply continues.
                        if (wr_cnt_q != '0) begin
                            line_ready_d = 1'b1;
                            line_len_d   = wr_cnt_q;
                            hello_d      = hello_hit;
                            state_d      = HOLD;
                        end
                    end else if (wr_cnt_q < CntW'(DEPTH)) begin
                        mem_we   = 1'b1;
                        wr_cnt_d = wr_cnt_q + CntW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Anything arriving while a line is held is lost, even on the final read cycle.
                if (accept) begin
                    rx_drop_d = 1'b1;
                end
                if (rd_en && (rd_ptr_q < line_len_q)) begin
                    rd_data_d  = line_mem_q[rd_ptr_q[AW-1:0]];
                    rd_valid_d = 1'b1;
                    if (rd_ptr_q == line_len_q - CntW'(1)) begin
                        line_ready_d = 1'b0;
                        hello_d      = 1'b0;
                        line_len_d   = '0;
                        wr_cnt_d     = '0;
                        rd_ptr_d     = '0;
                        state_d      = COLLECT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + CntW'(1);
                    end
                end
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= COLLECT;
            wr_cnt_q     <= '0;
            rd_ptr_q     <= '0;
            line_len_q   <= '0;
            line_ready_q <= 1'b0;
            hello_q      <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            rx_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            line_len_q   <= line_len_d;
            line_ready_q <= line_ready_d;
            hello_q      <= hello_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            overflow_q   <= overflow_d;
            rx_drop_q    <= rx_drop_d;
        end
    end

    // Line storage; contents are don't-care until written, so no reset.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            line_mem_q[wr_cnt_q[AW-1:0]] <= RxData;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign line_ready  = line_ready_q;
    assign line_len    = line_len_q;
    assign hello_match = hello_q;
    assign overflow    = overflow_q;
    assign rx_drop     = rx_drop_q;

endmodule

// File: tb/tb_uart_rx_line_buffer.sv
// Testbench for uart_rx_line_buffer: directed scenarios plus randomized traffic against a line model.
module tb_uart_rx_line_buffer;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          Clk    = 1'b0;
    logic          Rst_n  = 1'b0;
    logic          RxDone = 1'b0;
    logic [7:0]    RxData = 8'h00;
    logic          rd_en  = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          line_ready;
    logic [LW-1:0] line_len;
    logic          hello_match;
    logic          overflow;
    logic          rx_drop;

    uart_rx_line_buffer #(
        .DEPTH (DEPTH),
        .TERM  (8'h0D),
        .SKIP  (8'h0A)
    ) dut (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .RxDone      (RxDone),
        .RxData      (RxData),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .line_ready  (line_ready),
        .line_len    (line_len),
        .hello_match (hello_match),
        .overflow    (overflow),
        .rx_drop     (rx_drop)
    );

    always #10 Clk = ~Clk;

    int tests_run = 0;
    int failed    = 0;

    // Observed pulses and read data, sampled just after each rising edge.
    logic [7:0] rd_q[$];
    int         ovf_seen  = 0;
    int         drop_seen = 0;

    always @(posedge Clk) begin
        #1;
        if (rd_valid === 1'b1) rd_q.push_back(rd_data);
        if (overflow === 1'b1) ovf_seen++;
        if (rx_drop === 1'b1) drop_seen++;
    end

    // Reference model: the line as a byte queue plus a held flag.
    logic [7:0] m_line[$];
    bit         m_held   = 1'b0;
    int         m_rd_idx = 0;
    int         exp_ovf  = 0;
    int         exp_drop = 0;
    logic [7:0] exp_rd[$];

    function automatic void model_reset();
        m_line.delete();
        m_held   = 1'b0;
        m_rd_idx = 0;
    endfunction

    function automatic void model_accept(input logic [7:0] b);
        if (m_held) exp_drop++;
        else if (b == 8'h0A) begin end
        else if (b == 8'h0D) begin
            if (m_line.size() > 0) m_held = 1'b1;
        end else if (m_line.size() < DEPTH) m_line.push_back(b);
        else exp_ovf++;
    endfunction

    function automatic void model_read();
        if (m_held && m_rd_idx < m_line.size()) begin
            exp_rd.push_back(m_line[m_rd_idx]);
            m_rd_idx++;
            if (m_rd_idx == m_line.size()) model_reset();
        end
    endfunction

    function automatic bit model_hello();
        if (!m_held || m_line.size() != 5) return 1'b0;
        return m_line[0] == 8'h48 && m_line[1] == 8'h45 && m_line[2] == 8'h4C &&
               m_line[3] == 8'h4C && m_line[4] == 8'h4F;
    endfunction

    function automatic int model_len();
        return m_held ? m_line.size() : 0;
    endfunction

    task automatic clear_obs();
        rd_q.delete();
        exp_rd.delete();
        ovf_seen  = 0;
        drop_seen = 0;
        exp_ovf   = 0;
        exp_drop  = 0;
    endtask

    task automatic settle();
        repeat (3) @(negedge Clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi);
        @(negedge Clk);
        RxDone = 1'b1;
        RxData = b;
        model_accept(b);
        repeat (hi) @(negedge Clk);
        RxDone = 1'b0;
        RxData = 8'($urandom);
    endtask

    task automatic send_str(input string s, input int hi);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], hi);
    endtask

    task automatic do_reads(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            rd_en = 1'b1;
            model_read();
        end
        @(negedge Clk);
        rd_en = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        repeat (2) @(negedge Clk);
        tests_run++;
        if ({rd_data, rd_valid, line_ready, line_len, hello_match, overflow, rx_drop} !== '0) begin
            failed++;
            $display("FAIL reset_outputs: got %0h required 0",
                     {rd_data, rd_valid, line_ready, line_len, hello_match, overflow, rx_drop});
        end
        Rst_n = 1'b1;
        model_reset();
        settle();
    endtask

    task automatic test_hello();
        clear_obs();
        send_str("HELLO\r", 3);
        settle();
        tests_run++;
        if (line_ready !== 1'b1 || line_len !== LW'(5) || hello_match !== 1'b1) begin
            failed++;
            $display("FAIL hello_held: got ready=%b len=%0d match=%b required 1/5/1",
                     line_ready, line_len, hello_match);
        end
        do_reads(5);
        tests_run++;
        if (rd_q.size() != 5) begin
            failed++;
            $display("FAIL hello_count: got %0d reads required 5", rd_q.size());
        end
        for (int i = 0; i < 5 && i < rd_q.size(); i++) begin
            tests_run++;
            if (rd_q[i] !== exp_rd[i]) begin
                failed++;
                $display("FAIL hello_data[%0d]: got %h required %h", i, rd_q[i], exp_rd[i]);
            end
        end
        tests_run++;
        if (line_ready !== 1'b0 || line_len !== '0 || hello_match !== 1'b0) begin
            failed++;
            $display("FAIL hello_drained: got ready=%b len=%0d match=%b required 0/0/0",
                     line_ready, line_len, hello_match);
        end
    endtask

    task automatic test_help_lf();
        logic [7:0] want [4];
        want = '{8'h48, 8'h45, 8'h4C, 8'h50};
        clear_obs();
        send_str("HELP\n\r", 2);
        settle();
        tests_run++;
        if (line_ready !== 1'b1 || line_len !== LW'(4) || hello_match !== 1'b0) begin
            failed++;
            $display("FAIL help_held: got ready=%b len=%0d match=%b required 1/4/0",
                     line_ready, line_len, hello_match);
        end
        do_reads(4);
        tests_run++;
        if (rd_q.size() != 4) begin
            failed++;
            $display("FAIL help_count: got %0d reads required 4", rd_q.size());
        end
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            tests_run++;
            if (rd_q[i] !== want[i]) begin
                failed++;
                $display("FAIL help_data[%0d]: got %h required %h", i, rd_q[i], want[i]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_obs();
        for (int i = 0; i < 18; i++) send_byte(8'h41, 1 + (i % 3));
        send_byte(8'h0D, 2);
        settle();
        tests_run++;
        if (ovf_seen != 2) begin
            failed++;
            $display("FAIL ovf_pulses: got %0d required 2", ovf_seen);
        end
        tests_run++;
        if (line_ready !== 1'b1 || line_len !== LW'(16)) begin
            failed++;
            $display("FAIL ovf_len: got ready=%b len=%0d required 1/16", line_ready, line_len);
        end
        do_reads(16);
        tests_run++;
        if (rd_q.size() != 16) begin
            failed++;
            $display("FAIL ovf_count: got %0d reads required 16", rd_q.size());
        end
        for (int i = 0; i < rd_q.size(); i++) begin
            tests_run++;
            if (rd_q[i] !== 8'h41) begin
                failed++;
                $display("FAIL ovf_data[%0d]: got %h required 41", i, rd_q[i]);
            end
        end
        tests_run++;
        if (line_ready !== 1'b0) begin
            failed++;
            $display("FAIL ovf_drained: got ready=%b required 0", line_ready);
        end
    endtask

    task automatic test_rx_drop();
        clear_obs();
        send_str("AB\r", 2);
        settle();
        send_byte(8'h43, 3);
        settle();
        tests_run++;
        if (drop_seen != 1) begin
            failed++;
            $display("FAIL drop_pulses: got %0d required 1", drop_seen);
        end
        do_reads(3);
        tests_run++;
        if (rd_q.size() != 2) begin
            failed++;
            $display("FAIL drop_count: got %0d reads required 2", rd_q.size());
        end else begin
            tests_run++;
            if (rd_q[0] !== 8'h41 || rd_q[1] !== 8'h42) begin
                failed++;
                $display("FAIL drop_data: got %h %h required 41 42", rd_q[0], rd_q[1]);
            end
        end
    endtask

    task automatic test_empty_line();
        clear_obs();
        send_byte(8'h0D, 2);
        settle();
        tests_run++;
        if (line_ready !== 1'b0) begin
            failed++;
            $display("FAIL empty_line: got ready=%b required 0", line_ready);
        end
        send_str("X\r", 2);
        settle();
        tests_run++;
        if (line_ready !== 1'b1 || line_len !== LW'(1)) begin
            failed++;
            $display("FAIL x_line: got ready=%b len=%0d required 1/1", line_ready, line_len);
        end
        do_reads(1);
        tests_run++;
        if (rd_q.size() != 1 || rd_q[0] !== 8'h58) begin
            failed++;
            $display("FAIL x_data: got %0d reads first %h required 1 read 58",
                     rd_q.size(), rd_q.size() > 0 ? rd_q[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_midline();
        clear_obs();
        send_str("HELLO\r", 2);
        settle();
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        tests_run++;
        if ({rd_data, rd_valid, line_ready, line_len, hello_match, overflow, rx_drop} !== '0) begin
            failed++;
            $display("FAIL reset_held_outputs: got %0h required 0",
                     {rd_data, rd_valid, line_ready, line_len, hello_match, overflow, rx_drop});
        end
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        send_str("HE", 2);
        // RxDone held high across a reset pulse must still be accepted once afterwards.
        @(negedge Clk);
        RxDone = 1'b1;
        RxData = 8'h4F;
        Rst_n  = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();
        model_accept(8'h4F);
        repeat (3) @(negedge Clk);
        RxDone = 1'b0;
        send_byte(8'h0D, 2);
        settle();
        tests_run++;
        if (line_ready !== 1'b1 || line_len !== LW'(1) || hello_match !== 1'b0) begin
            failed++;
            $display("FAIL midreset_line: got ready=%b len=%0d match=%b required 1/1/0",
                     line_ready, line_len, hello_match);
        end
        clear_obs();
        do_reads(1);
        tests_run++;
        if (rd_q.size() != 1 || rd_q[0] !== 8'h4F) begin
            failed++;
            $display("FAIL midreset_data: got %0d reads first %h required 1 read 4f",
                     rd_q.size(), rd_q.size() > 0 ? rd_q[0] : 8'hxx);
        end
    endtask

    task automatic test_simultaneous();
        clear_obs();
        send_str("AB\r", 2);
        settle();
        @(negedge Clk);
        rd_en = 1'b1;
        model_read();
        @(negedge Clk);
        RxDone = 1'b1;
        RxData = 8'h43;
        model_accept(8'h43);
        model_read();
        @(negedge Clk);
        rd_en = 1'b0;
        @(negedge Clk);
        RxDone = 1'b0;
        settle();
        send_byte(8'h0D, 2);
        settle();
        tests_run++;
        if (drop_seen != exp_drop) begin
            failed++;
            $display("FAIL simul_drop: got %0d required %0d", drop_seen, exp_drop);
        end
        tests_run++;
        if (rd_q.size() != 2 || rd_q[0] !== 8'h41 || rd_q[1] !== 8'h42) begin
            failed++;
            $display("FAIL simul_data: got %0d reads required 41 42", rd_q.size());
        end
        tests_run++;
        if (line_ready !== 1'b0) begin
            failed++;
            $display("FAIL simul_no_line: got ready=%b required 0", line_ready);
        end
    endtask

    task automatic test_random();
        logic [7:0] alpha [8];
        alpha = '{8'h48, 8'h45, 8'h4C, 8'h4F, 8'h41, 8'h0D, 8'h0A, 8'h6C};
        clear_obs();
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0:       send_str("HELLO\r", $urandom_range(1, 3));
                1, 2:    do_reads($urandom_range(1, 7));
                default: send_byte(alpha[$urandom_range(0, 7)], $urandom_range(1, 4));
            endcase
            settle();
            tests_run++;
            if (line_ready !== m_held || line_len !== LW'(model_len()) ||
                hello_match !== model_hello()) begin
                failed++;
                $display("FAIL rand_state[%0d]: got %b/%0d/%b required %b/%0d/%b", it,
                         line_ready, line_len, hello_match, m_held, model_len(), model_hello());
            end
        end
        do_reads(DEPTH + 1);
        tests_run++;
        if (ovf_seen != exp_ovf || drop_seen != exp_drop) begin
            failed++;
            $display("FAIL rand_pulses: got ovf=%0d drop=%0d required ovf=%0d drop=%0d",
                     ovf_seen, drop_seen, exp_ovf, exp_drop);
        end
        tests_run++;
        if (rd_q.size() != exp_rd.size()) begin
            failed++;
            $display("FAIL rand_count: got %0d reads required %0d", rd_q.size(), exp_rd.size());
        end
        for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) begin
            tests_run++;
            if (rd_q[i] !== exp_rd[i]) begin
                failed++;
                $display("FAIL rand_data[%0d]: got %h required %h", i, rd_q[i], exp_rd[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_help_lf();
        test_overflow();
        test_rx_drop();
        test_empty_line();
        test_reset_midline();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
